// File: rtl/win_check.sv
// win_check: connect-four board evaluator (7 cols x 6 rows).
// Ports: clk, rst (sync, active-high), start, panel[col][row] in;
//        busy (scanning), done (1-cycle result pulse), winner, draw out.
module win_check (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [6:0][5:0][1:0] panel,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           winner,
  output logic                 draw
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  state_t               nxt;
  logic [6:0][5:0][1:0] snap;
  logic [2:0]           col;
  logic [2:0]           row;
  logic [1:0]           code;
  logic [3:0]           ac;
  logic [3:0]           ar;
  logic                 l0;
  logic                 l1;
  logic                 l2;
  logic                 l3;
  logic                 hit;
  logic                 full;
  logic                 last;

  // Off-board coordinates read as empty, so lines that leave
  // the board can never match a player anchor.
  function automatic logic [1:0] at(
    input logic [6:0][5:0][1:0] b,
    input logic [3:0]           c,
    input logic [3:0]           r
  );
    logic [1:0] v;
    v = 2'b00;
    for (int i = 0; i < 7; i++) begin
      for (int j = 0; j < 6; j++) begin
        if (c == 4'(i) && r == 4'(j)) v = b[i][j];
      end
    end
    return v;
  endfunction

  always_comb begin
    code = snap[col][row];
    ac   = {1'b0, col};
    ar   = {1'b0, row};
    l0   = 1'b1;
    l1   = 1'b1;
    l2   = 1'b1;
    l3   = 1'b1;
    hit  = 1'b0;
    for (int k = 1; k < 4; k++) begin
      l0 = l0 & (at(snap, ac + 4'(k), ar) == code);
      l1 = l1 & (at(snap, ac, ar + 4'(k)) == code);
      l2 = l2 & (at(snap, ac + 4'(k), ar + 4'(k)) == code);
      l3 = l3 & (at(snap, ac + 4'(k), ar - 4'(k)) == code);
    end
    if (code == 2'b01 || code == 2'b10) begin
      hit = l0 | l1 | l2 | l3;
    end
  end

  // A cell is occupied only for codes 01/10, i.e. when its bits differ.
  always_comb begin
    full = 1'b1;
    for (int i = 0; i < 7; i++) begin
      for (int j = 0; j < 6; j++) begin
        full = full & (^snap[i][j]);
      end
    end
  end

  assign last = (col == 3'd6) && (row == 3'd5);

  always_comb begin
    nxt = state;
    unique case (1'b1)
      (state == IDLE): if (start) nxt = SCAN;
      (state == SCAN): if (hit || last) nxt = DONE;
      (state == DONE): nxt = IDLE;
      default:         nxt = IDLE;
    endcase
  end

  assign busy = (state == SCAN);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (state == IDLE && start && !rst) begin
      snap <= panel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      col    <= 3'd0;
      row    <= 3'd0;
      winner <= 2'b00;
      draw   <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && start) begin
        col    <= 3'd0;
        row    <= 3'd0;
        winner <= 2'b00;
        draw   <= 1'b0;
      end else if (state == SCAN) begin
        if (hit) begin
          winner <= code;
        end else if (last) begin
          draw <= full;
        end else if (row == 3'd5) begin
          row <= 3'd0;
          col <= col + 3'd1;
        end else begin
          row <= row + 3'd1;
        end
      end
    end
  end

endmodule
